// File: rtl/zoom_hphase_gen.sv
// zoom_hphase_gen: horizontal DDA phase generator (source indices + 6-bit weights) for the ZOOM scaler.
// Optional ZOOM_CENTER_ALIGN_EN selects pixel-centre initial phase. Rev 1.0
`default_nettype none

module zoom_hphase_gen #(
  parameter int W_W    = 11,
  parameter int STEP_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_W-1:0]    src_width,
  input  logic [W_W-1:0]    dst_width,
  input  logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_W-1:0]    src_x0,
  output logic [W_W-1:0]    src_x1,
  output logic [5:0]        w0,
  output logic [5:0]        w1,
  output logic              copy,
  output logic              last
);

  localparam int ACC_W = W_W + 6;
  localparam logic [W_W-1:0] ONE = W_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W_W-1:0]      srcw_q, srcw_d;
  logic [W_W-1:0]      dstw_q, dstw_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [W_W-1:0]      cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [W_W-1:0]      x0_q, x0_d;
  logic [W_W-1:0]      x1_q, x1_d;
  logic [5:0]          w0_q, w0_d;
  logic [5:0]          w1_q, w1_d;
  logic                copy_q, copy_d;
  logic                last_q, last_d;
  logic                load_out;
  logic                clr_last;
  logic [ACC_W-1:0]    init_phase;

`ifdef ZOOM_CENTER_ALIGN_EN
  logic [STEP_W-1:0] half_step;
  assign half_step  = step >> 1;
  assign init_phase = (half_step < STEP_W'(32)) ? '0 : ACC_W'(half_step - STEP_W'(32));
`else
  assign init_phase = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      srcw_q  <= '0;
      dstw_q  <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      copy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      srcw_q  <= srcw_d;
      dstw_q  <= dstw_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      copy_q  <= copy_d;
      last_q  <= last_d;
    end
  end

  // acc/cnt always describe the pixel currently presented on the outputs.
  always_comb begin
    state_d  = state_q;
    srcw_d   = srcw_q;
    dstw_d   = dstw_q;
    step_d   = step_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    load_out = 1'b0;
    clr_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          srcw_d = src_width;
          dstw_d = dst_width;
          step_d = step;
          acc_d  = init_phase;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (dst_width == '0) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_RUN;
            valid_d  = 1'b1;
            load_out = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (cnt_q == dstw_q - ONE) begin
            state_d  = S_FIN;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            clr_last = 1'b1;
          end else begin
            acc_d    = acc_q + ACC_W'(step_q);
            cnt_d    = cnt_q + ONE;
            load_out = 1'b1;
          end
        end
      end
      S_FIN: begin
        valid_d = 1'b0;
        // An empty line enters with busy still set and needs one extra cycle before done.
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  logic [W_W-1:0] int_part;
  logic [W_W:0]   int_p1;
  logic [W_W-1:0] sw_m1;
  logic [5:0]     frac;
  logic           clamp;

  always_comb begin
    int_part = acc_d[ACC_W-1:6];
    frac     = acc_d[5:0];
    sw_m1    = srcw_d - ONE;
    clamp    = int_part > sw_m1;
    int_p1   = {1'b0, int_part} + (W_W+1)'(1);
    x0_d     = x0_q;
    x1_d     = x1_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    copy_d   = copy_q;
    last_d   = last_q;
    if (load_out) begin
      x0_d   = clamp ? sw_m1 : int_part;
      x1_d   = (int_p1 > {1'b0, sw_m1}) ? sw_m1 : int_p1[W_W-1:0];
      copy_d = clamp | (frac == 6'd0);
      w1_d   = clamp ? 6'd0 : frac;
      // 64-frac in six bits is the two's complement of frac for frac in 1..63.
      w0_d   = (clamp | (frac == 6'd0)) ? 6'd0 : 6'd0 - frac;
      last_d = (cnt_d == dstw_d - ONE);
    end else if (clr_last) begin
      last_d = 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign src_x0    = x0_q;
  assign src_x1    = x1_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign copy      = copy_q;
  assign last      = last_q;

endmodule

`default_nettype wire
